// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the instruction-fetch slice.
// Holds the PC/vector constants, the IMEM word-address width, the FSM state
// encoding and the redirect-priority encoding used by fetch_ctrl.
package fetch_pkg;

    localparam logic [31:0] PC_RESET    = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC     = 32'h0000_4180;
    localparam int          IMEM_AW     = 11;
    localparam int          TIMEOUT_CYC = 64;
    localparam int          TMO_W       = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    // Redirect sources, resolved so that an exception always wins.
    typedef enum logic [1:0] {
        RD_NONE    = 2'd0,
        RD_BRANCH  = 2'd1,
        RD_BAD_TGT = 2'd2,
        RD_EXC     = 2'd3
    } redir_e;

    // Exception beats branch; a branch to an unusable target becomes RD_BAD_TGT.
    function automatic redir_e redir_sel(input logic exc, input logic br, input logic tgt_ok);
        redir_e r;
        if (exc)
            r = RD_EXC;
        else if (br && tgt_ok)
            r = RD_BRANCH;
        else if (br)
            r = RD_BAD_TGT;
        else
            r = RD_NONE;
        return r;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// fetch_if: req/ready handshake between the fetch controller (master) and the
// variable-latency instruction memory (slave).
interface fetch_if;
    import fetch_pkg::*;

    logic               req;
    logic [IMEM_AW-1:0] addr;
    logic               ready;
    logic [31:0]        rdata;

    modport master (output req, output addr, input ready, input rdata);
    modport slave  (input req, input addr, output ready, output rdata);

endinterface

// File: rtl/fetch_addr_map.sv
// fetch_addr_map: byte PC -> IMEM word address, plus range/alignment flags.
// Used for the running pc and for checking branch targets.
module fetch_addr_map
    import fetch_pkg::*;
(
    input  logic [31:0]        pc,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic               in_range,
    output logic               aligned
);

    logic [31:0] offset;
    logic        unused_lsb;

    assign offset     = pc - PC_RESET;
    // Truncation is deliberate: a sequential run off the end wraps to word 0.
    assign imem_addr  = offset[IMEM_AW+1:2];
    assign aligned    = (pc[1:0] == 2'b00);
    assign in_range   = (pc >= PC_RESET) && (offset[31:IMEM_AW+2] == '0);
    assign unused_lsb = ^offset[1:0];

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: F-stage fetch sequencer. Owns the PC, runs the IMEM req/ready
// handshake and presents instr_F/pc_F/valid_F to the F/D register. Handles
// hazard stalls, branch redirects and exception redirects (highest priority).
// Optional watchdog on stuck memory requests: define FETCH_TIMEOUT_EN.
module fetch_ctrl
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_D,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        exc_req,
    fetch_if.master     imem,
    output logic [31:0] pc_F,
    output logic [31:0] instr_F,
    output logic        valid_F,
    output logic        addr_err
`ifdef FETCH_TIMEOUT_EN
    ,
    output logic        timeout_flag
`endif
);

    fetch_state_e       state, state_nxt;
    logic [31:0]        pc, pc_nxt;
    logic [31:0]        pc_F_nxt, instr_F_nxt;
    logic               valid_F_nxt;
    logic [IMEM_AW-1:0] drain_addr, drain_addr_nxt;

    logic [IMEM_AW-1:0] pc_word;
    logic               pc_in_range, pc_aligned;
    logic [IMEM_AW-1:0] tgt_word;
    logic               tgt_in_range, tgt_aligned;
    logic               unused_map;

    logic               req_on;
    redir_e             redir;
    logic               tmo_hit;
    logic               redirect;
    logic [31:0]        redir_pc;
    logic               addr_err_nxt;

    fetch_addr_map u_pc_map (
        .pc        (pc),
        .imem_addr (pc_word),
        .in_range  (pc_in_range),
        .aligned   (pc_aligned)
    );

    fetch_addr_map u_tgt_map (
        .pc        (br_target),
        .imem_addr (tgt_word),
        .in_range  (tgt_in_range),
        .aligned   (tgt_aligned)
    );

    // The running pc needs no checking and the target's word address is unused.
    assign unused_map = ^{pc_in_range, pc_aligned, tgt_word};

    assign req_on    = (state == ST_REQ) || (state == ST_DRAIN);
    assign imem.req  = req_on;
    // DRAIN keeps presenting the abandoned request's address until it completes.
    assign imem.addr = (state == ST_DRAIN) ? drain_addr : pc_word;

    assign redir = redir_sel(exc_req, br_taken, tgt_in_range && tgt_aligned);

`ifdef FETCH_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt;

    assign tmo_hit = req_on && !imem.ready && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    // Watchdog: count cycles a request waits; clear on ready or any redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt      <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (!req_on || imem.ready || redirect)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (tmo_hit)
                timeout_flag <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Explicit redirects take precedence over a coincident watchdog expiry.
    assign redirect     = (redir != RD_NONE) || tmo_hit;
    assign redir_pc     = (redir == RD_BRANCH) ? br_target : EXC_VEC;
    assign addr_err_nxt = (redir == RD_BAD_TGT) || ((redir == RD_NONE) && tmo_hit);

    // Next-state and next-register values for the fetch FSM.
    always_comb begin
        // NOTE: every variable gets a default before the case so no latch is inferred.
        state_nxt      = state;
        pc_nxt         = pc;
        pc_F_nxt       = pc_F;
        instr_F_nxt    = instr_F;
        valid_F_nxt    = valid_F;
        drain_addr_nxt = drain_addr;

        case (state)
            ST_IDLE: begin
                state_nxt = ST_REQ;
                if (redirect)
                    pc_nxt = redir_pc;
            end

            ST_REQ: begin
                if (redirect) begin
                    pc_nxt      = redir_pc;
                    valid_F_nxt = 1'b0;
                    // The memory cannot abort, so an outstanding request is drained.
                    if (!imem.ready) begin
                        state_nxt      = ST_DRAIN;
                        drain_addr_nxt = pc_word;
                    end
                end else if (imem.ready) begin
                    instr_F_nxt = imem.rdata;
                    pc_F_nxt    = pc;
                    valid_F_nxt = 1'b1;
                    if (stall_D)
                        state_nxt = ST_HOLD;
                    else
                        pc_nxt = pc + 32'd4;
                end else begin
                    valid_F_nxt = 1'b0;
                end
            end

            ST_HOLD: begin
                if (redirect) begin
                    pc_nxt      = redir_pc;
                    valid_F_nxt = 1'b0;
                    state_nxt   = ST_REQ;
                end else if (!stall_D) begin
                    pc_nxt      = pc + 32'd4;
                    valid_F_nxt = 1'b0;
                    state_nxt   = ST_REQ;
                end
            end

            ST_DRAIN: begin
                valid_F_nxt = 1'b0;
                if (redirect)
                    pc_nxt = redir_pc;
                // Returned data is discarded; once it lands the old request is gone.
                if (imem.ready)
                    state_nxt = ST_REQ;
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, PC and F/D-facing registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pc         <= PC_RESET;
            pc_F       <= '0;
            instr_F    <= '0;
            valid_F    <= 1'b0;
            drain_addr <= '0;
            addr_err   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state      <= state_nxt;
            pc         <= pc_nxt;
            pc_F       <= pc_F_nxt;
            instr_F    <= instr_F_nxt;
            valid_F    <= valid_F_nxt;
            drain_addr <= drain_addr_nxt;
            addr_err   <= addr_err_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: self-checking bench for fetch_ctrl. A variable-latency memory
// model returns the word address as data; expected fetches are queued per test
// and compared as each new valid instruction appears. Timeout scenario runs
// only when FETCH_TIMEOUT_EN is defined.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_D;
    logic        br_taken;
    logic [31:0] br_target;
    logic        exc_req;
    logic [31:0] pc_F;
    logic [31:0] instr_F;
    logic        valid_F;
    logic        addr_err;
`ifdef FETCH_TIMEOUT_EN
    logic        timeout_flag;
`endif

    int checks = 0;
    int errors = 0;

    exp_t        sb_q[$];
    bit          sb_en = 1'b0;
    logic        prev_valid = 1'b0;
    logic [31:0] prev_pc = '0;

    int   mem_wait  = 0;
    logic mem_block = 1'b0;
    int   wcnt      = 0;

    fetch_if imem_bus ();

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall_D   (stall_D),
        .br_taken  (br_taken),
        .br_target (br_target),
        .exc_req   (exc_req),
        .imem      (imem_bus),
        .pc_F      (pc_F),
        .instr_F   (instr_F),
        .valid_F   (valid_F),
        .addr_err  (addr_err)
`ifdef FETCH_TIMEOUT_EN
        ,
        .timeout_flag (timeout_flag)
`endif
    );

    // Memory model: ready after mem_wait idle cycles, data = word address.
    assign imem_bus.ready = imem_bus.req && !mem_block && (wcnt >= mem_wait);
    assign imem_bus.rdata = 32'(imem_bus.addr);

    always @(posedge clk) begin
        if (imem_bus.req && !imem_bus.ready)
            wcnt <= wcnt + 1;
        else
            wcnt <= 0;
    end

    function automatic logic [31:0] word_of(input logic [31:0] p);
        logic [31:0] off;
        off = p - PC_RESET;
        return 32'(off[IMEM_AW+1:2]);
    endfunction

    function automatic void push_exp(input logic [31:0] p);
        exp_t e;
        e.pc    = p;
        e.instr = word_of(p);
        sb_q.push_back(e);
    endfunction

    // Scoreboard monitor: pop one expectation per newly presented instruction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_en && valid_F && (!prev_valid || pc_F != prev_pc) && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (pc_F !== e.pc || instr_F !== e.instr) begin
                    errors++;
                    $display("FAIL sb_fetch: got pc_F=%h instr_F=%h, expected pc_F=%h instr_F=%h",
                             pc_F, instr_F, e.pc, e.instr);
                end
            end
            prev_valid = valid_F;
            prev_pc    = pc_F;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        stall_D   = 1'b0;
        br_taken  = 1'b0;
        br_target = '0;
        exc_req   = 1'b0;
        mem_wait  = 0;
        mem_block = 1'b0;
        sb_en     = 1'b0;
        sb_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_sb(input int budget);
        for (int i = 0; i < budget && sb_q.size() != 0; i++)
            @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d expected fetches never seen, next pc %h",
                     sb_q.size(), sb_q[0].pc);
        end
        sb_en = 1'b0;
        sb_q.delete();
    endtask

    task automatic wait_valid_pc(input logic [31:0] p);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (valid_F && pc_F == p)
                seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL sync_pc: pc_F=%h valid_F=%b, required valid pc_F=%h", pc_F, valid_F, p);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        stall_D   = 1'b0;
        br_taken  = 1'b0;
        br_target = '0;
        exc_req   = 1'b0;
        @(negedge clk);
        checks++;
        if ({imem_bus.req, valid_F, addr_err} !== 3'b000 || pc_F !== '0 || instr_F !== '0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b valid=%b err=%b pc_F=%h instr_F=%h, required all 0",
                     imem_bus.req, valid_F, addr_err, pc_F, instr_F);
        end
        checks++;
        if (imem_bus.addr !== '0) begin
            errors++;
            $display("FAIL reset_addr: imem_addr=%h, required 0", imem_bus.addr);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({imem_bus.req, valid_F, addr_err} !== 3'b000 || pc_F !== '0 || instr_F !== '0) begin
            errors++;
            $display("FAIL async_reset: req=%b valid=%b err=%b pc_F=%h instr_F=%h, required all 0",
                     imem_bus.req, valid_F, addr_err, pc_F, instr_F);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_wait();
        do_reset();
        push_exp(32'h3000);
        push_exp(32'h3004);
        push_exp(32'h3008);
        sb_en = 1'b1;
        @(negedge clk);
        checks++;
        if ({valid_F, imem_bus.req} !== 2'b01 || imem_bus.addr !== 11'd0) begin
            errors++;
            $display("FAIL zw_cycle1: valid=%b req=%b addr=%h, required valid=0 req=1 addr=0",
                     valid_F, imem_bus.req, imem_bus.addr);
        end
        @(negedge clk);
        checks++;
        if (valid_F !== 1'b1 || pc_F !== 32'h3000 || imem_bus.addr !== 11'd1) begin
            errors++;
            $display("FAIL zw_cycle2: valid=%b pc_F=%h addr=%h, required valid=1 pc_F=3000 addr=1",
                     valid_F, pc_F, imem_bus.addr);
        end
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            checks++;
            if (valid_F !== 1'b1 || pc_F !== 32'h3000 + 32'(4 * k)) begin
                errors++;
                $display("FAIL zw_b2b: valid=%b pc_F=%h, required valid=1 pc_F=%h",
                         valid_F, pc_F, 32'h3000 + 32'(4 * k));
            end
        end
        wait_sb(10);
    endtask

    task automatic test_wait_states();
        int addr0_cyc;
        int valid_cyc;
        do_reset();
        mem_wait = 3;
        push_exp(32'h3000);
        push_exp(32'h3004);
        sb_en = 1'b1;
        addr0_cyc = 0;
        valid_cyc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (imem_bus.req && imem_bus.addr == 11'd0)
                addr0_cyc++;
            if (valid_F)
                valid_cyc++;
        end
        checks++;
        if (addr0_cyc != 4) begin
            errors++;
            $display("FAIL ws_addr_hold: addr 0 held %0d cycles, required 4", addr0_cyc);
        end
        checks++;
        if (valid_cyc != 2) begin
            errors++;
            $display("FAIL ws_valid_pulse: valid_F high %0d cycles in window, required 2", valid_cyc);
        end
        wait_sb(20);
    endtask

    task automatic test_stall();
        do_reset();
        for (int k = 0; k < 4; k++)
            push_exp(32'h3000 + 32'(4 * k));
        sb_en = 1'b1;
        wait_valid_pc(32'h3004);
        stall_D = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({valid_F, imem_bus.req} !== 2'b10 || pc_F !== 32'h3008) begin
                errors++;
                $display("FAIL stall_hold: valid=%b req=%b pc_F=%h, required valid=1 req=0 pc_F=3008",
                         valid_F, imem_bus.req, pc_F);
            end
        end
        stall_D = 1'b0;
        @(negedge clk);
        checks++;
        if ({valid_F, imem_bus.req} !== 2'b01 || imem_bus.addr !== 11'd3) begin
            errors++;
            $display("FAIL stall_resume: valid=%b req=%b addr=%h, required valid=0 req=1 addr=3",
                     valid_F, imem_bus.req, imem_bus.addr);
        end
        wait_sb(10);
    endtask

    task automatic test_branch_drain();
        bit seen;
        do_reset();
        mem_wait = 2;
        for (int k = 0; k < 4; k++)
            push_exp(32'h3000 + 32'(4 * k));
        push_exp(32'h3040);
        sb_en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (imem_bus.req && imem_bus.addr == 11'd4)
                seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL br_sync: request for addr 4 never issued");
        end
        br_taken  = 1'b1;
        br_target = 32'h3040;
        @(negedge clk);
        br_taken = 1'b0;
        checks++;
        if ({imem_bus.req, valid_F, addr_err} !== 3'b100 || imem_bus.addr !== 11'd4) begin
            errors++;
            $display("FAIL br_drain: req=%b valid=%b err=%b addr=%h, required req=1 valid=0 err=0 addr=4",
                     imem_bus.req, valid_F, addr_err, imem_bus.addr);
        end
        wait_sb(30);
    endtask

    task automatic test_exc_priority();
        do_reset();
        push_exp(32'h3000);
        push_exp(32'h3004);
        push_exp(32'h4180);
        push_exp(32'h4184);
        sb_en = 1'b1;
        wait_valid_pc(32'h3004);
        exc_req   = 1'b1;
        br_taken  = 1'b1;
        br_target = 32'h3100;
        stall_D   = 1'b1;
        @(negedge clk);
        exc_req  = 1'b0;
        br_taken = 1'b0;
        stall_D  = 1'b0;
        checks++;
        if ({valid_F, addr_err} !== 2'b00 || imem_bus.addr !== 11'h460) begin
            errors++;
            $display("FAIL exc_redirect: valid=%b err=%b addr=%h, required valid=0 err=0 addr=460",
                     valid_F, addr_err, imem_bus.addr);
        end
        wait_sb(10);
    endtask

    task automatic test_bad_target();
        logic [31:0] tgt_tab[5] = '{32'h3042, 32'h2FFC, 32'h5000, 32'h4FFC, 32'h3040};
        logic        bad_tab[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] exp_pc;
        for (int t = 0; t < 5; t++) begin
            do_reset();
            exp_pc = bad_tab[t] ? EXC_VEC : tgt_tab[t];
            push_exp(32'h3000);
            push_exp(32'h3004);
            push_exp(exp_pc);
            push_exp(exp_pc + 32'd4);
            sb_en = 1'b1;
            wait_valid_pc(32'h3004);
            br_taken  = 1'b1;
            br_target = tgt_tab[t];
            @(negedge clk);
            br_taken = 1'b0;
            checks++;
            if (addr_err !== bad_tab[t]) begin
                errors++;
                $display("FAIL tgt_addr_err: target=%h addr_err=%b, required %b",
                         tgt_tab[t], addr_err, bad_tab[t]);
            end
            @(negedge clk);
            checks++;
            if (addr_err !== 1'b0) begin
                errors++;
                $display("FAIL tgt_err_pulse: target=%h addr_err=%b one cycle later, required 0",
                         tgt_tab[t], addr_err);
            end
            wait_sb(10);
        end
    endtask

`ifdef FETCH_TIMEOUT_EN
    task automatic test_timeout();
        int waited;
        bit hit;
        do_reset();
        mem_block = 1'b1;
        waited = 0;
        hit    = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (addr_err)
                hit = 1'b1;
            else if (imem_bus.req)
                waited++;
        end
        checks++;
        if (!hit || waited != TIMEOUT_CYC) begin
            errors++;
            $display("FAIL tmo_cycle: hit=%b after %0d waiting cycles, required hit after %0d",
                     hit, waited, TIMEOUT_CYC);
        end
        checks++;
        if (timeout_flag !== 1'b1 || imem_bus.req !== 1'b1 || imem_bus.addr !== 11'd0) begin
            errors++;
            $display("FAIL tmo_drain: flag=%b req=%b addr=%h, required flag=1 req=1 addr=0",
                     timeout_flag, imem_bus.req, imem_bus.addr);
        end
        push_exp(EXC_VEC);
        sb_en     = 1'b1;
        mem_block = 1'b0;
        wait_sb(10);
        checks++;
        if (timeout_flag !== 1'b1) begin
            errors++;
            $display("FAIL tmo_sticky: timeout_flag=%b, required 1", timeout_flag);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall();
        test_branch_drain();
        test_exc_priority();
        test_bad_target();
`ifdef FETCH_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
